// File: rtl/vend_multi.sv
// Parametrised vending controller: 50/100-yen coins, cancel/refund, multi-unit change payout.
// Optional sales counter built only when VEND_SALES_COUNT_EN is defined; otherwise sold_cnt is tied to 0.
module vend_multi #(
  parameter int unsigned PRICE = 3,
  parameter int unsigned CW    = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic            ck,
  input  logic            res_n,
  input  logic            c0,
  input  logic            c1,
  input  logic            cancel,
  output logic            y_item,
  output logic            y_chg,
  output logic            y_rej,
  output logic            busy,
  output logic [CW-1:0]   credit,
  output logic [CNTW-1:0] sold_cnt
);

  localparam int unsigned SW = CW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VEND   = 2'd1;
  localparam logic [1:0] CHANGE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic [SW-1:0] sum;

  // One extra bit keeps credit + coin value exact before the price compare.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    sum        = {1'b0, credit} + SW'({c1, c0});
    case (state)
      IDLE: begin
        if (cancel) begin
          if (sum != '0) begin
            credit_nxt = CW'(sum);
            state_nxt  = CHANGE;
          end
        end else if (sum >= SW'(PRICE)) begin
          credit_nxt = CW'(sum - SW'(PRICE));
          state_nxt  = VEND;
        end else begin
          credit_nxt = CW'(sum);
        end
      end
      VEND: begin
        state_nxt = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (credit <= CW'(1)) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          credit_nxt = credit - CW'(1);
        end
      end
      default: begin
        credit_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // Moore outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      state  <= IDLE;
      credit <= '0;
      y_item <= 1'b0;
      y_chg  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      y_item <= (state_nxt == VEND);
      y_chg  <= (state_nxt == CHANGE);
      busy   <= (state_nxt != IDLE);
    end
  end

  assign y_rej = busy & (c0 | c1);

`ifdef VEND_SALES_COUNT_EN
  logic [CNTW-1:0] sold_q;

  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      sold_q <= '0;
    end else if (state_nxt == VEND) begin
      sold_q <= sold_q + CNTW'(1);
    end
  end

  assign sold_cnt = sold_q;
`else
  assign sold_cnt = '0;
`endif

endmodule

// File: tb/tb_vend_multi.sv
// Directed bench for vend_multi with PRICE=3, CW=4, CNTW=2.
module tb_vend_multi;

  localparam int unsigned PRICE = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned CNTW  = 2;

  logic            ck;
  logic            res_n;
  logic            c0;
  logic            c1;
  logic            cancel;
  logic            y_item;
  logic            y_chg;
  logic            y_rej;
  logic            busy;
  logic [CW-1:0]   credit;
  logic [CNTW-1:0] sold_cnt;

  int total;
  int bad;

  vend_multi #(.PRICE(PRICE), .CW(CW), .CNTW(CNTW)) dut (
    .ck       (ck),
    .res_n    (res_n),
    .c0       (c0),
    .c1       (c1),
    .cancel   (cancel),
    .y_item   (y_item),
    .y_chg    (y_chg),
    .y_rej    (y_rej),
    .busy     (busy),
    .credit   (credit),
    .sold_cnt (sold_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive inputs for one clock edge, then observe just after the edge.
  task automatic apply(input logic a, input logic b, input logic c);
    c0 = a; c1 = b; cancel = c;
    @(posedge ck);
    #1;
    c0 = 1'b0; c1 = 1'b0; cancel = 1'b0;
  endtask

  task automatic outs(input string tag, input int it, input int ch, input int bz, input int cr);
    check({tag, ".y_item"}, int'(y_item), it);
    check({tag, ".y_chg"},  int'(y_chg),  ch);
    check({tag, ".busy"},   int'(busy),   bz);
    check({tag, ".credit"}, int'(credit), cr);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    @(posedge ck);
    #1;
    res_n = 1'b1;
    @(posedge ck);
    #1;
  endtask

  int exp_sold [5];

  initial begin
    total = 0; bad = 0;
    c0 = 1'b0; c1 = 1'b0; cancel = 1'b0; res_n = 1'b0;
`ifdef VEND_SALES_COUNT_EN
    exp_sold = '{1, 2, 3, 0, 1};
`else
    exp_sold = '{0, 0, 0, 0, 0};
`endif
    #2;
    outs("rst", 0, 0, 0, 0);
    check("rst.sold", int'(sold_cnt), 0);
    do_reset();
    outs("rst_rel", 0, 0, 0, 0);

    // Three 50-yen coins: exact price, no change.
    apply(1, 0, 0); outs("t1.c1", 0, 0, 0, 1);
    apply(1, 0, 0); outs("t1.c2", 0, 0, 0, 2);
    apply(1, 0, 0); outs("t1.vend", 1, 0, 1, 0);
    apply(0, 0, 0); outs("t1.idle", 0, 0, 0, 0);

    // Two 100-yen coins: one unit change.
    apply(0, 1, 0); outs("t2.c1", 0, 0, 0, 2);
    apply(0, 1, 0); outs("t2.vend", 1, 0, 1, 1);
    apply(0, 0, 0); outs("t2.chg", 0, 1, 1, 1);
    apply(0, 0, 0); outs("t2.idle", 0, 0, 0, 0);

    // Credit 2 plus both coins: maximum overshoot, two change pulses.
    apply(0, 1, 0); outs("t3.c1", 0, 0, 0, 2);
    apply(1, 1, 0); outs("t3.vend", 1, 0, 1, 2);
    apply(0, 0, 0); outs("t3.chg1", 0, 1, 1, 2);
    apply(0, 0, 0); outs("t3.chg2", 0, 1, 1, 1);
    apply(0, 0, 0); outs("t3.idle", 0, 0, 0, 0);

    // Cancel refund of 2 units.
    apply(0, 1, 0); outs("t4.c1", 0, 0, 0, 2);
    apply(0, 0, 1); outs("t4.chg1", 0, 1, 1, 2);
    apply(0, 0, 0); outs("t4.chg2", 0, 1, 1, 1);
    apply(0, 0, 0); outs("t4.idle", 0, 0, 0, 0);

    // Cancel with zero credit stays idle.
    apply(0, 0, 1); outs("t4b.nop", 0, 0, 0, 0);

    // Cancel wins over reaching the price; full 3-unit refund, cancel ignored while busy.
    apply(1, 0, 0); apply(1, 0, 0); outs("t4c.c2", 0, 0, 0, 2);
    apply(1, 0, 1); outs("t4c.chg1", 0, 1, 1, 3);
    apply(0, 0, 1); outs("t4c.chg2", 0, 1, 1, 2);
    apply(0, 0, 0); outs("t4c.chg3", 0, 1, 1, 1);
    apply(0, 0, 0); outs("t4c.idle", 0, 0, 0, 0);

    // Coin while idle is not rejected; coin while paying out is rejected and ignored.
    c0 = 1'b1; #1; check("t5.rej_idle", int'(y_rej), 0);
    c0 = 1'b0;
    apply(0, 1, 0); outs("t5.c1", 0, 0, 0, 3 - 1);
    apply(0, 0, 1); outs("t5.chg1", 0, 1, 1, 2);
    c0 = 1'b1; #1; check("t5.rej_busy", int'(y_rej), 1);
    apply(1, 0, 0); outs("t5.chg2", 0, 1, 1, 1);
    res_n = 1'b0; #1;
    outs("t5.rst_async", 0, 0, 0, 0);
    @(posedge ck); #1;
    res_n = 1'b1;
    apply(0, 0, 0); outs("t5.after", 0, 0, 0, 0);
    check("t5.sold", int'(sold_cnt), 0);

    // Five exact-price vends exercise the sales counter wrap.
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 0);
      check($sformatf("t6.y_item%0d", i), int'(y_item), 1);
      check($sformatf("t6.sold%0d", i), int'(sold_cnt), exp_sold[i]);
      apply(0, 0, 0);
      check($sformatf("t6.idle%0d", i), int'(busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
